// File: rtl/dynamic_buffer_insert_engine.sv
// ---------------------------------------------------------------------------
// dynamic_buffer_insert_engine
//
// Purpose:
//   Allocates packet-buffer slots from an internal free list and links them
//   into singly linked chains. Each accepted insert beat takes the oldest free
//   slot, writes the beat payload into the slot RAM and, when the beat has a
//   predecessor, writes the predecessor's next pointer. After reset the free
//   list is filled with slot indices 0..N-1, one per cycle. Released slots
//   are pushed back to the tail of the free list.
//
//   MAX_DB_SLOT_NUM_LOG (L) and PACKET_BUFFER_SLOT_WIDTH (W) normally come
//   from the protocol engine definitions. They are parameters here so the
//   block stands alone. N = 2^L slots.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   insert_req_valid_i       insert beat valid
//   insert_req_start_i       beat starts a new chain (first beat only)
//   insert_req_last_i        final beat of the transaction
//   insert_req_head_i  [L]   tail of an existing chain (first beat, start=0)
//   insert_req_data_i  [W]   slot payload
//   insert_req_ready_o       insert beat accept
//   insert_resp_valid_o      one-cycle pulse per completed transaction
//   insert_resp_data_o [L]   first slot allocated in the transaction
//   free_req_valid_i/_data_i/_ready_o   slot release handshake
//   data_wr_en_o/_addr_o/_data_o        slot payload RAM write port
//   next_wr_en_o/_addr_o/_data_o        next-pointer RAM write port
//   free_count_o       [L+1] number of free slots
// ---------------------------------------------------------------------------
module dynamic_buffer_insert_engine #(
    parameter int MAX_DB_SLOT_NUM_LOG      = 4,
    parameter int PACKET_BUFFER_SLOT_WIDTH = 32,
    localparam int L = MAX_DB_SLOT_NUM_LOG,
    localparam int W = PACKET_BUFFER_SLOT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         insert_req_valid_i,
    input  logic         insert_req_start_i,
    input  logic         insert_req_last_i,
    input  logic [L-1:0] insert_req_head_i,
    input  logic [W-1:0] insert_req_data_i,
    output logic         insert_req_ready_o,

    output logic         insert_resp_valid_o,
    output logic [L-1:0] insert_resp_data_o,

    input  logic         free_req_valid_i,
    input  logic [L-1:0] free_req_data_i,
    output logic         free_req_ready_o,

    output logic         data_wr_en_o,
    output logic [L-1:0] data_wr_addr_o,
    output logic [W-1:0] data_wr_data_o,

    output logic         next_wr_en_o,
    output logic [L-1:0] next_wr_addr_o,
    output logic [L-1:0] next_wr_data_o,

    output logic [L:0]   free_count_o
);

    localparam int       N        = 1 << L;
    localparam logic [L:0]   FULL_CNT = {1'b1, {L{1'b0}}};
    localparam logic [L-1:0] LAST_IDX = {L{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t       state_q;

    // Free-list storage and pointers. Pointers are exactly L bits wide so
    // they wrap modulo N on their own.
    logic [L-1:0] fifo_mem_q [N];
    logic [L-1:0] rd_ptr_q;
    logic [L-1:0] wr_ptr_q;
    logic [L-1:0] init_idx_q;
    logic [L:0]   free_count_q;
    logic [L:0]   free_count_d;

    // Transaction context: slot of the previous beat and of the first beat.
    logic [L-1:0] prev_slot_q;
    logic [L-1:0] first_slot_q;

    // Registered outputs.
    logic         data_wr_en_q;
    logic [L-1:0] data_wr_addr_q;
    logic [W-1:0] data_wr_data_q;
    logic         next_wr_en_q;
    logic [L-1:0] next_wr_addr_q;
    logic [L-1:0] next_wr_data_q;
    logic         resp_valid_q;
    logic [L-1:0] resp_data_q;

    logic         ins_ready;
    logic         free_ready;
    logic         ins_acc;
    logic         free_acc;
    logic         push;
    logic         first_beat;
    logic         pred_valid;
    logic [L-1:0] pred_slot;
    logic [L-1:0] pop_slot;
    logic         mem_we;
    logic [L-1:0] mem_wdata;

    // Handshake readiness depends on registers only, so there is no
    // combinational path from the request inputs to the ready outputs.
    always_comb begin
        ins_ready  = (state_q != ST_INIT) && (free_count_q != '0);
        free_ready = (state_q != ST_INIT) && (free_count_q != FULL_CNT);
        ins_acc    = insert_req_valid_i && ins_ready;
        free_acc   = free_req_valid_i && free_ready;
        push       = (state_q == ST_INIT) || free_acc;

        // In IDLE the next accepted beat opens a transaction; start is only
        // meaningful there, later beats always link to the previous slot.
        first_beat = (state_q == ST_IDLE);
        pred_valid = first_beat ? !insert_req_start_i : 1'b1;
        pred_slot  = first_beat ? insert_req_head_i : prev_slot_q;

        pop_slot   = fifo_mem_q[rd_ptr_q];

        mem_we     = !rst && push;
        mem_wdata  = (state_q == ST_INIT) ? init_idx_q : free_req_data_i;

        free_count_d = free_count_q;
        case ({push, ins_acc})
            2'b10:   free_count_d = free_count_q + (L+1)'(1);
            2'b01:   free_count_d = free_count_q - (L+1)'(1);
            default: free_count_d = free_count_q;
        endcase
    end

    // Free-list storage write port (no reset on the array itself).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            fifo_mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            init_idx_q     <= '0;
            free_count_q   <= '0;
            prev_slot_q    <= '0;
            first_slot_q   <= '0;
            data_wr_en_q   <= 1'b0;
            data_wr_addr_q <= '0;
            data_wr_data_q <= '0;
            next_wr_en_q   <= 1'b0;
            next_wr_addr_q <= '0;
            next_wr_data_q <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
        end else begin
            data_wr_en_q <= 1'b0;
            next_wr_en_q <= 1'b0;
            resp_valid_q <= 1'b0;
            free_count_q <= free_count_d;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            case (state_q)
                ST_INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    if (ins_acc) begin
                        rd_ptr_q       <= rd_ptr_q + 1'b1;
                        data_wr_en_q   <= 1'b1;
                        data_wr_addr_q <= pop_slot;
                        data_wr_data_q <= insert_req_data_i;
                        next_wr_en_q   <= pred_valid;
                        next_wr_addr_q <= pred_slot;
                        next_wr_data_q <= pop_slot;
                        prev_slot_q    <= pop_slot;
                        if (first_beat) begin
                            first_slot_q <= pop_slot;
                        end
                        if (insert_req_last_i) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= first_beat ? pop_slot : first_slot_q;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q      <= ST_BUSY;
                        end
                    end
                end
            endcase
        end
    end

    assign insert_req_ready_o  = ins_ready;
    assign free_req_ready_o    = free_ready;
    assign insert_resp_valid_o = resp_valid_q;
    assign insert_resp_data_o  = resp_data_q;
    assign data_wr_en_o        = data_wr_en_q;
    assign data_wr_addr_o      = data_wr_addr_q;
    assign data_wr_data_o      = data_wr_data_q;
    assign next_wr_en_o        = next_wr_en_q;
    assign next_wr_addr_o      = next_wr_addr_q;
    assign next_wr_data_o      = next_wr_data_q;
    assign free_count_o        = free_count_q;

endmodule

// File: tb/tb_dynamic_buffer_insert_engine.sv
// ---------------------------------------------------------------------------
// Testbench for dynamic_buffer_insert_engine.
// A reference model keeps the free list as a queue of slot numbers and the
// open transaction as (busy, previous slot, first slot). Every cycle the
// expected write-port / response / free_count picture is compared with the
// DUT one cycle after the stimulus edge.
// ---------------------------------------------------------------------------
module tb_dynamic_buffer_insert_engine;

    localparam int L  = 4;
    localparam int W  = 16;
    localparam int N  = 1 << L;
    localparam int VW = 4 + 5 * L + W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         insert_req_valid_i = 1'b0;
    logic         insert_req_start_i = 1'b0;
    logic         insert_req_last_i  = 1'b0;
    logic [L-1:0] insert_req_head_i  = '0;
    logic [W-1:0] insert_req_data_i  = '0;
    logic         insert_req_ready_o;
    logic         insert_resp_valid_o;
    logic [L-1:0] insert_resp_data_o;
    logic         free_req_valid_i   = 1'b0;
    logic [L-1:0] free_req_data_i    = '0;
    logic         free_req_ready_o;
    logic         data_wr_en_o;
    logic [L-1:0] data_wr_addr_o;
    logic [W-1:0] data_wr_data_o;
    logic         next_wr_en_o;
    logic [L-1:0] next_wr_addr_o;
    logic [L-1:0] next_wr_data_o;
    logic [L:0]   free_count_o;

    always #5 clk = ~clk;

    dynamic_buffer_insert_engine #(
        .MAX_DB_SLOT_NUM_LOG      (L),
        .PACKET_BUFFER_SLOT_WIDTH (W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .insert_req_valid_i  (insert_req_valid_i),
        .insert_req_start_i  (insert_req_start_i),
        .insert_req_last_i   (insert_req_last_i),
        .insert_req_head_i   (insert_req_head_i),
        .insert_req_data_i   (insert_req_data_i),
        .insert_req_ready_o  (insert_req_ready_o),
        .insert_resp_valid_o (insert_resp_valid_o),
        .insert_resp_data_o  (insert_resp_data_o),
        .free_req_valid_i    (free_req_valid_i),
        .free_req_data_i     (free_req_data_i),
        .free_req_ready_o    (free_req_ready_o),
        .data_wr_en_o        (data_wr_en_o),
        .data_wr_addr_o      (data_wr_addr_o),
        .data_wr_data_o      (data_wr_data_o),
        .next_wr_en_o        (next_wr_en_o),
        .next_wr_addr_o      (next_wr_addr_o),
        .next_wr_data_o      (next_wr_data_o),
        .free_count_o        (free_count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int free_q[$];
    int init_left = N;
    bit m_busy    = 1'b0;
    int m_prev    = 0;
    int m_first   = 0;

    logic [1:0]    exp_rdy, obs_rdy;
    logic [VW-1:0] exp_vec, obs_vec;

    // Drive one cycle starting at a falling edge, advance the model, then
    // sample the DUT 1 time unit after the rising edge. Returns at the next
    // falling edge.
    task automatic drive_cycle(input bit rv, input bit iv, input bit st, input bit la,
                               input logic [L-1:0] hd, input logic [W-1:0] dt,
                               input bit fv, input logic [L-1:0] fd);
        bit           e_ins_rdy, e_fr_rdy;
        bit           e_dwe, e_nwe, e_rv;
        int           e_da, e_na, e_nd, e_rd, s;
        logic [W-1:0] e_dd;
        logic [L+W-1:0] e_d, o_d;
        logic [2*L-1:0] e_n, o_n;
        logic [L-1:0]   e_r, o_r;
        e_dwe = 0; e_nwe = 0; e_rv = 0;
        e_da = 0; e_na = 0; e_nd = 0; e_rd = 0; e_dd = '0;

        rst                = rv;
        insert_req_valid_i = iv;
        insert_req_start_i = st;
        insert_req_last_i  = la;
        insert_req_head_i  = hd;
        insert_req_data_i  = dt;
        free_req_valid_i   = fv;
        free_req_data_i    = fd;
        #1;
        obs_rdy   = {insert_req_ready_o, free_req_ready_o};
        e_ins_rdy = (init_left == 0) && (free_q.size() > 0);
        e_fr_rdy  = (init_left == 0) && (free_q.size() < N);
        exp_rdy   = {e_ins_rdy, e_fr_rdy};

        if (rv) begin
            free_q.delete();
            init_left = N;
            m_busy    = 1'b0;
        end else if (init_left > 0) begin
            free_q.push_back(N - init_left);
            init_left--;
        end else begin
            if (iv && e_ins_rdy) begin
                s     = free_q.pop_front();
                e_dwe = 1; e_da = s; e_dd = dt;
                if (!m_busy) begin
                    m_first = s;
                    if (!st) begin
                        e_nwe = 1; e_na = int'(hd); e_nd = s;
                    end
                end else begin
                    e_nwe = 1; e_na = m_prev; e_nd = s;
                end
                m_prev = s;
                if (la) begin
                    e_rv = 1; e_rd = m_first; m_busy = 1'b0;
                end else begin
                    m_busy = 1'b1;
                end
            end
            if (fv && e_fr_rdy) free_q.push_back(int'(fd));
        end

        e_d = e_dwe ? {L'(e_da), e_dd} : '0;
        e_n = e_nwe ? {L'(e_na), L'(e_nd)} : '0;
        e_r = e_rv ? L'(e_rd) : '0;
        exp_vec = {e_dwe, e_d, e_nwe, e_n, e_rv, e_r, (L+1)'(free_q.size())};

        @(posedge clk);
        #1;
        o_d = data_wr_en_o ? {data_wr_addr_o, data_wr_data_o} : '0;
        o_n = next_wr_en_o ? {next_wr_addr_o, next_wr_data_o} : '0;
        o_r = insert_resp_valid_o ? insert_resp_data_o : '0;
        obs_vec = {data_wr_en_o, o_d, next_wr_en_o, o_n, insert_resp_valid_o, o_r, free_count_o};
        if (insert_resp_valid_o === 1'b1)
            $display("txn complete: first slot %0d, free_count %0d", insert_resp_data_o, free_count_o);
        @(negedge clk);
    endtask

    // Reset followed by the full free-list load (stimulus only).
    task automatic reset_init();
        drive_cycle(1, 0, 0, 0, '0, '0, 0, '0);
        for (int c = 0; c < N; c++) drive_cycle(0, 0, 0, 0, '0, '0, 0, '0);
    endtask

    task automatic test_reset();
        drive_cycle(1, 1, 1, 1, '0, 16'h1234, 1, '0);
        drive_cycle(1, 1, 1, 1, '0, 16'h5678, 1, '0);
        checks++;
        if ({insert_req_ready_o, free_req_ready_o, insert_resp_valid_o, insert_resp_data_o,
             data_wr_en_o, data_wr_addr_o, data_wr_data_o, next_wr_en_o, next_wr_addr_o,
             next_wr_data_o, free_count_o} !== '0)
            begin errors++; $display("FAIL reset_outputs: got ready=%b/%b wr=%b/%b cnt=%0d, want all zero",
                insert_req_ready_o, free_req_ready_o, data_wr_en_o, next_wr_en_o, free_count_o); end
        checks++;
        if (obs_vec !== exp_vec) begin errors++;
            $display("FAIL reset_vec: got %h want %h", obs_vec, exp_vec); end
    endtask

    task automatic test_init();
        int zero_cnt = 0;
        for (int c = 0; c < N + 2; c++) begin
            // Requests during the load must be ignored.
            drive_cycle(0, c < N, 1, 1, '0, W'(c), c < N, L'(c));
            if (obs_rdy[1] === 1'b0) zero_cnt++;
            checks++;
            if (obs_rdy !== exp_rdy) begin errors++;
                $display("FAIL init_ready c=%0d: got %b want %b", c, obs_rdy, exp_rdy); end
            checks++;
            if (obs_vec !== exp_vec) begin errors++;
                $display("FAIL init_vec c=%0d: got %h want %h", c, obs_vec, exp_vec); end
        end
        checks++;
        if (zero_cnt !== N) begin errors++;
            $display("FAIL init_len: got %0d not-ready cycles want %0d", zero_cnt, N); end
        checks++;
        if ({insert_req_ready_o, free_count_o} !== {1'b1, (L+1)'(N)}) begin errors++;
            $display("FAIL init_done: got ready=%b cnt=%0d want ready=1 cnt=%0d",
                     insert_req_ready_o, free_count_o, N); end
    endtask

    task automatic test_single();
        logic [W-1:0] d = W'($urandom);
        drive_cycle(0, 1, 1, 1, L'(9), d, 0, '0);
        checks++;
        if ({data_wr_en_o, data_wr_addr_o, data_wr_data_o, next_wr_en_o, insert_resp_valid_o,
             insert_resp_data_o, free_count_o} !==
            {1'b1, L'(0), d, 1'b0, 1'b1, L'(0), (L+1)'(N - 1)}) begin errors++;
            $display("FAIL single_beat: got wr=%b@%0d d=%h nwr=%b resp=%b/%0d cnt=%0d want wr@0 d=%h no link resp 0 cnt %0d",
                     data_wr_en_o, data_wr_addr_o, data_wr_data_o, next_wr_en_o,
                     insert_resp_valid_o, insert_resp_data_o, free_count_o, d, N - 1); end
        checks++;
        if (obs_vec !== exp_vec) begin errors++;
            $display("FAIL single_vec: got %h want %h", obs_vec, exp_vec); end
    endtask

    task automatic test_chain3();
        reset_init();
        for (int b = 0; b < 3; b++) begin
            drive_cycle(0, 1, b == 0, b == 2, L'($urandom), W'($urandom), 0, '0);
            checks++;
            if (obs_vec !== exp_vec) begin errors++;
                $display("FAIL chain3_vec b=%0d: got %h want %h", b, obs_vec, exp_vec); end
            checks++;
            if ({data_wr_en_o, data_wr_addr_o} !== {1'b1, L'(b)}) begin errors++;
                $display("FAIL chain3_slot b=%0d: got en=%b addr=%0d want addr %0d",
                         b, data_wr_en_o, data_wr_addr_o, b); end
            checks++;
            if (next_wr_en_o !== (b > 0) ||
                (b > 0 && {next_wr_addr_o, next_wr_data_o} !== {L'(b - 1), L'(b)})) begin errors++;
                $display("FAIL chain3_link b=%0d: got en=%b %0d->%0d", b, next_wr_en_o,
                         next_wr_addr_o, next_wr_data_o); end
            checks++;
            if (insert_resp_valid_o !== (b == 2) || (b == 2 && insert_resp_data_o !== '0)) begin errors++;
                $display("FAIL chain3_resp b=%0d: got %b/%0d want %b/0", b,
                         insert_resp_valid_o, insert_resp_data_o, b == 2); end
        end
    endtask

    task automatic test_append();
        // Slots 0..2 are taken by the previous chain, so slot 3 is next.
        drive_cycle(0, 1, 0, 1, L'(5), W'($urandom), 0, '0);
        checks++;
        if ({next_wr_en_o, next_wr_addr_o, next_wr_data_o, insert_resp_valid_o, insert_resp_data_o}
            !== {1'b1, L'(5), L'(3), 1'b1, L'(3)}) begin errors++;
            $display("FAIL append: got link=%b %0d->%0d resp=%b/%0d want 5->3 resp 3",
                     next_wr_en_o, next_wr_addr_o, next_wr_data_o, insert_resp_valid_o,
                     insert_resp_data_o); end
        checks++;
        if (obs_vec !== exp_vec) begin errors++;
            $display("FAIL append_vec: got %h want %h", obs_vec, exp_vec); end
    endtask

    task automatic test_exhaust();
        reset_init();
        for (int i = 0; i < N; i++) begin
            drive_cycle(0, 1, i == 0, 0, '0, W'(i), 0, '0);
            checks++;
            if (obs_vec !== exp_vec) begin errors++;
                $display("FAIL exhaust_vec i=%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        // Empty: beat held, then a free of slot 7 arrives with the beat waiting.
        drive_cycle(0, 1, 0, 0, '0, 16'hAAAA, 1, L'(7));
        checks++;
        if ({obs_rdy[1], data_wr_en_o} !== 2'b00) begin errors++;
            $display("FAIL exhaust_stall: got ready=%b wr=%b want 0/0", obs_rdy[1], data_wr_en_o); end
        checks++;
        if (obs_vec !== exp_vec) begin errors++;
            $display("FAIL exhaust_free_vec: got %h want %h", obs_vec, exp_vec); end
        drive_cycle(0, 1, 0, 0, '0, 16'hBBBB, 0, '0);
        checks++;
        if ({data_wr_en_o, data_wr_addr_o, next_wr_en_o, next_wr_addr_o, next_wr_data_o}
            !== {1'b1, L'(7), 1'b1, L'(N - 1), L'(7)}) begin errors++;
            $display("FAIL exhaust_resume: got wr=%b@%0d link %0d->%0d want wr@7 link %0d->7",
                     data_wr_en_o, data_wr_addr_o, next_wr_addr_o, next_wr_data_o, N - 1); end
        drive_cycle(0, 1, 0, 1, '0, 16'hCCCC, 1, L'(2));
        drive_cycle(0, 1, 0, 1, '0, 16'hCCCC, 0, '0);
        checks++;
        if ({insert_resp_valid_o, insert_resp_data_o, data_wr_addr_o} !== {1'b1, L'(0), L'(2)}) begin errors++;
            $display("FAIL exhaust_close: got resp=%b/%0d wr@%0d want resp 0 wr@2",
                     insert_resp_valid_o, insert_resp_data_o, data_wr_addr_o); end
    endtask

    task automatic test_simul_and_reset();
        reset_init();
        for (int i = 0; i < N - 3; i++) drive_cycle(0, 1, i == 0, i == N - 4, '0, W'(i), 0, '0);
        drive_cycle(0, 1, 1, 1, '0, 16'h0F0F, 1, L'(0));
        checks++;
        if ({data_wr_en_o, free_count_o} !== {1'b1, (L+1)'(3)}) begin errors++;
            $display("FAIL simul_count: got wr=%b cnt=%0d want wr=1 cnt=3", data_wr_en_o, free_count_o); end
        checks++;
        if (obs_vec !== exp_vec) begin errors++;
            $display("FAIL simul_vec: got %h want %h", obs_vec, exp_vec); end
        drive_cycle(0, 1, 1, 0, '0, 16'h1111, 0, '0);
        drive_cycle(1, 1, 0, 1, '0, 16'h2222, 1, L'(4));
        checks++;
        if ({data_wr_en_o, next_wr_en_o, insert_resp_valid_o, insert_req_ready_o, free_count_o} !== '0) begin errors++;
            $display("FAIL midrst: got wr=%b nwr=%b resp=%b ready=%b cnt=%0d want all 0",
                     data_wr_en_o, next_wr_en_o, insert_resp_valid_o, insert_req_ready_o, free_count_o); end
        for (int c = 0; c < N + 1; c++) begin
            drive_cycle(0, 1, 0, 1, '0, W'(c), 0, '0);
            checks++;
            if (obs_rdy !== exp_rdy || obs_vec !== exp_vec) begin errors++;
                $display("FAIL reinit c=%0d: got %b/%h want %b/%h", c, obs_rdy, obs_vec, exp_rdy, exp_vec); end
        end
    endtask

    task automatic test_back_to_back();
        reset_init();
        for (int i = 0; i < 24; i++) begin
            drive_cycle(0, 1, 1, 1, '0, W'($urandom), i > 2, L'(i - 3));
            checks++;
            if (obs_rdy !== exp_rdy || obs_vec !== exp_vec) begin errors++;
                $display("FAIL b2b i=%0d: got %b/%h want %b/%h", i, obs_rdy, obs_vec, exp_rdy, exp_vec); end
        end
    endtask

    task automatic test_random();
        reset_init();
        for (int i = 0; i < 600; i++) begin
            drive_cycle(($urandom % 250) == 0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
                        L'($urandom), W'($urandom), ($urandom % 3) == 0, L'($urandom));
            checks++;
            if (obs_rdy !== exp_rdy) begin errors++;
                $display("FAIL rand_ready i=%0d: got %b want %b", i, obs_rdy, exp_rdy); end
            checks++;
            if (obs_vec !== exp_vec) begin errors++;
                $display("FAIL rand_vec i=%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_init();
        test_single();
        test_chain3();
        test_append();
        test_exhaust();
        test_simul_and_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dynamic_buffer_insert_engine.md
DYNAMIC_BUFFER_INSERT_ENGINE -- requirements
Module: DynamicBufferInsertEngine

Interface
REQ-001 The block SHALL use `MAX_DB_SLOT_NUM_LOG` (slot index width, L) and `PACKET_BUFFER_SLOT_WIDTH` (slot data width, W) from protocol_engine_def.vh, with N = 2^L slots.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 insert_req_valid / insert_req_start / insert_req_last  in  1 each  beat valid, first beat of new chain, final beat of transaction.
REQ-005 insert_req_head  in  L  tail slot of existing chain; used only on a transaction's first beat when start=0.
REQ-006 insert_req_data  in  W  slot payload.
REQ-007 insert_req_ready  out  1  beat accept.
REQ-008 insert_resp_valid  out  1  one-cycle pulse per completed transaction.
REQ-009 insert_resp_data  out  L  first slot allocated in the transaction.
REQ-010 free_req_valid  in  1,  free_req_data  in  L,  free_req_ready  out  1  slot release handshake.
REQ-011 data_wr_en  out  1,  data_wr_addr  out  L,  data_wr_data  out  W  slot payload RAM write port.
REQ-012 next_wr_en  out  1,  next_wr_addr  out  L,  next_wr_data  out  L  next-pointer RAM write port.
REQ-013 free_count  out  L+1  current number of free slots.

Function
REQ-014 States: INIT, IDLE, BUSY; a transaction is all beats from first accepted beat through the beat with last=1.
REQ-015 INIT: internal free-list FIFO (depth N) loaded with indices 0..N-1 ascending, one per cycle; after N cycles go to IDLE with free_count=N.
REQ-016 In INIT, insert_req_ready=0 and free_req_ready=0.
REQ-017 insert_req_ready SHALL be 1 only in IDLE or BUSY with free_count>0; a beat is accepted when valid&&ready.
REQ-018 Each accepted beat pops one slot S (FIFO order) from the free list.
REQ-019 One cycle after acceptance: data_wr_en=1, data_wr_addr=S, data_wr_data=beat data.
REQ-020 Link: if the beat has a predecessor P (previous beat of the same transaction, or insert_req_head on a first beat with start=0), then one cycle after acceptance next_wr_en=1, next_wr_addr=P, next_wr_data=S; first beat with start=1 writes no link.
REQ-021 IDLE->BUSY on accepting a first beat with last=0; BUSY->IDLE on accepting last=1; an accepted first beat with last=1 stays in IDLE.
REQ-022 start on non-first beats SHALL be ignored.
REQ-023 insert_resp_valid pulses one cycle after the last beat is accepted; insert_resp_data = slot allocated to that transaction's first beat.
REQ-024 free_req_ready=1 outside INIT when free_count<N; an accepted free pushes free_req_data into the FIFO.
REQ-025 Simultaneous alloc and free in one cycle: free_count unchanged; freed slot enqueued behind existing entries.
REQ-026 free_count=0 mid-transaction: insert_req_ready=0, state held in BUSY, resumes when a slot is freed (earliest next cycle).
REQ-027 FIFO pointers wrap modulo N; free_count ranges 0..N inclusive.

Reset
REQ-028 On rst: state=INIT, FIFO pointers=0, free_count=0, all outputs 0 (ready, resp, write enables, addresses, data).
REQ-029 rst mid-transaction SHALL abandon the transaction with no response and restart INIT; no write strobes in the cycle after rst asserts.

Verification
REQ-030 Reset release -> ready=0 for N cycles, then free_count=N, insert_req_ready=1.
REQ-031 Single beat start=1,last=1, data=D -> next cycle data_wr_en@addr 0 data D, no next write, resp_valid with resp_data=0, free_count=N-1.
REQ-032 3-beat new chain after init -> slots 0,1,2 written; next writes 0->1, 1->2; one resp with resp_data=0 after beat 3.
REQ-033 Append: start=0, head=5, single beat -> slot allocated S, next_wr 5->S, resp_data=S.
REQ-034 Exhaust all N slots in one transaction with last withheld -> ready drops at free_count=0; free slot 7 -> next beat gets slot 7.
REQ-035 Alloc and free same cycle at free_count=3 -> free_count stays 3; assert rst during BUSY -> no resp, INIT restarts.
